snd_cmd_mailbox: RTL
====================

Name: snd_cmd_mailbox

Overview:
- Parametrised main-to-sound CPU command channel. It replaces the single sound-data latch and IRQ trigger pair between the CPU board and the sound board.
- Main CPU writes are buffered in a DEPTH-entry FIFO. The sound CPU reads them first-word-fall-through.
- The sound CPU interrupt is raised either by an explicit trigger edge (legacy Konami behaviour) or automatically whenever commands are pending.
- Sits between the CPU-board and sound-board instances in the arcade top level.

Parameters:
- DATA_W, 8, command word width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- IRQ_MODE, 0, 0 = IRQ set by rising edge of irq_trigger, cleared by ack; 1 = IRQ level equals "FIFO not empty".

Ports:
- clk_49m  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs_sounddata  in  1  main-CPU write strobe (level); one push per rising edge.
- cpubrd_Din  in  DATA_W  main-CPU write data, sampled in the edge cycle.
- irq_trigger  in  1  main-CPU interrupt request (level); rising edge is used, IRQ_MODE 0 only.
- snd_rd  in  1  sound-CPU read strobe; one pop per cycle it is high.
- snd_irq_ack  in  1  sound-CPU interrupt acknowledge, IRQ_MODE 0 only.
- ovf_clr  in  1  clears the sticky overflow flag.
- snd_dout  out  DATA_W  head-of-FIFO data.
- snd_irq  out  1  interrupt to the sound CPU.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:

Reset (asynchronous, all registers):
- wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0.
- snd_irq = 0, overflow = 0.
- Edge-detect registers for cs_sounddata and irq_trigger = 0. An input already high at reset release therefore produces one edge on the first clock.
- Storage contents are don't-care. snd_dout reads 0 while empty after reset.

Edge detection:
- push_req = cs_sounddata & ~cs_q.
- trig = irq_trigger & ~trig_q.
- cs_q and trig_q are registered copies of the inputs.

Push:
- If push_req and not full: mem[wr_ptr] <= cpubrd_Din, wr_ptr++ (wraps modulo DEPTH).
- If push_req and full, with no pop in the same cycle: data is dropped, pointers unchanged, overflow <= 1.

Pop:
- If snd_rd and not empty: rd_ptr++ (wraps).
- If snd_rd while empty: ignored. No pointer change, no flag.

Simultaneous push and pop:
- Full: both occur, count unchanged, no overflow.
- Empty: push only.
- Otherwise: both occur, count unchanged.

Data output:
- snd_dout = mem[rd_ptr], combinational from registers.
- A pushed word is visible on snd_dout the cycle after the push edge (latency 1).
- After a pop, the next entry is visible the following cycle.
- While empty, snd_dout holds the last popped word (0 after reset).

Flags:
- count, empty and full are registered and updated on the same edge as the pointers.
- full = (count == DEPTH).

overflow:
- Sticky.
- Cleared by ovf_clr.
- If ovf_clr and a new overflow occur in the same cycle, set wins.

IRQ_MODE 0:
- snd_irq <= 1 on trig.
- Otherwise snd_irq <= 0 on snd_irq_ack.
- trig and ack in the same cycle: set wins.
- Independent of FIFO state.

IRQ_MODE 1:
- snd_irq is a registered copy of ~empty; it follows empty with one extra cycle.
- irq_trigger and snd_irq_ack are ignored.

Reset during operation: all state is discarded immediately and asynchronously. Pending commands are lost.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33 via three separate cs_sounddata pulses -> count = 3, snd_dout = 0x11 one cycle after the first push; pops return 0x11, 0x22, 0x33, then empty = 1 and snd_dout holds 0x33.
2. DEPTH = 4: push 0xA0..0xA4 (five pushes) -> full = 1 after the fourth push, the fifth is dropped, overflow = 1; pops return 0xA0..0xA3; ovf_clr -> overflow = 0.
3. Full FIFO, push 0xB5 and snd_rd in the same cycle -> count stays 4, overflow stays 0, 0xB5 is read last after the four older entries.
4. cs_sounddata held high for 10 cycles with cpubrd_Din = 0x5A -> exactly one push (count = 1); snd_rd on an empty FIFO afterwards pops to empty with no pointer corruption (a subsequent push/pop returns the correct data).
5. IRQ_MODE 0: irq_trigger rising edge -> snd_irq = 1 the next cycle; trigger edge and ack in the same cycle -> snd_irq stays 1; ack alone -> snd_irq = 0.
6. IRQ_MODE 1: push 0x7E -> snd_irq = 1 two cycles after the push edge; pop -> snd_irq = 0 two cycles later. Assert reset mid-stream with 3 entries -> immediately count = 0, empty = 1, snd_irq = 0.

Source files
------------

// File: rtl/snd_cmd_mailbox.sv
// ============================================================================
// Module  : snd_cmd_mailbox
// Brief   : Main-to-sound CPU command FIFO (first-word-fall-through) with IRQ.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module snd_cmd_mailbox #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 4,
   parameter int IRQ_MODE = 0
) (
   input  logic                       clk_49m,
   input  logic                       reset,
   input  logic                       cs_sounddata,
   input  logic [DATA_W-1:0]          cpubrd_Din,
   input  logic                       irq_trigger,
   input  logic                       snd_rd,
   input  logic                       snd_irq_ack,
   input  logic                       ovf_clr,
   output logic [DATA_W-1:0]          snd_dout,
   output logic                       snd_irq,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] c_depth = CW'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_empty, r_full, r_ovf, r_irq;
   logic              r_cs_q, r_trig_q;
   logic [DATA_W-1:0] r_last;

   logic              w_push_req, w_trig, w_pop, w_push, w_drop;
   logic [CW-1:0]     w_count_nxt;

   assign w_push_req  = cs_sounddata & ~r_cs_q;
   assign w_trig      = irq_trigger & ~r_trig_q;
   assign w_pop       = snd_rd & ~r_empty;
   // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
   assign w_push      = w_push_req & (~r_full | w_pop);
   assign w_drop      = w_push_req & r_full & ~w_pop;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge clk_49m) begin
      if (w_push)
         r_mem[r_wr_ptr] <= cpubrd_Din;
   end

   always_ff @(posedge clk_49m or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_ovf    <= 1'b0;
         r_cs_q   <= 1'b0;
         r_trig_q <= 1'b0;
         r_last   <= '0;
      end else begin
         r_cs_q   <= cs_sounddata;
         r_trig_q <= irq_trigger;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr];
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == c_depth);
         if (w_drop)
            r_ovf <= 1'b1;
         else if (ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   generate
      if (IRQ_MODE == 0) begin : g_irq_edge
         always_ff @(posedge clk_49m or posedge reset) begin
            if (reset)
               r_irq <= 1'b0;
            else if (w_trig)
               r_irq <= 1'b1;
            else if (snd_irq_ack)
               r_irq <= 1'b0;
         end
      end else begin : g_irq_level
         always_ff @(posedge clk_49m or posedge reset) begin
            if (reset)
               r_irq <= 1'b0;
            else
               r_irq <= ~r_empty;
         end
      end
   endgenerate

   // The pop slot is not the last popped word, so show a held copy while empty.
   assign snd_dout = r_empty ? r_last : r_mem[r_rd_ptr];
   assign snd_irq  = r_irq;
   assign empty    = r_empty;
   assign full     = r_full;
   assign count    = r_count;
   assign overflow = r_ovf;

endmodule

`default_nettype wire
